seg_mux_n: RTL
==============

SEG_MUX_N -- requirements
Module: seg_mux_n

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 2400: SHOW-slot length per digit, in clk cycles; minimum 1.
REQ-003 Parameter BLANK_CYCLES, default 16: dead time before each digit slot, in clk cycles; 0 is legal.
REQ-004 clk  input  1  single system clock (on-chip oscillator).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 digits  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i.
REQ-007 digit_en  input  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-008 load  input  1  one-cycle strobe that captures digits and digit_en for the next frame.
REQ-009 seg  output  7  active-low segments, bit0=a ... bit6=g.
REQ-010 anode  output  NUM_DIGITS  active-low digit selects; at most one bit low in any cycle.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full frame.

Function
REQ-012 The FSM SHALL have two states:
  - BLANK: all anodes high, seg = 7'h7F.
  - SHOW: anode[idx] low if shadow_en[idx]=1, otherwise all anodes high.
REQ-013 The block SHALL stay in BLANK for exactly BLANK_CYCLES cycles, then go to SHOW.
REQ-014 When BLANK_CYCLES=0, the BLANK state SHALL never be entered.
REQ-015 The block SHALL stay in SHOW for exactly REFRESH_DIV cycles, then advance idx and return to BLANK (or stay in SHOW when BLANK_CYCLES=0).
REQ-016 idx SHALL increment 0..NUM_DIGITS-1 and wrap to 0; frame_done SHALL be high for exactly the cycle in which the wrap occurs.
REQ-017 A disabled digit SHALL still consume its full slot, so frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) regardless of digit_en.
REQ-018 During SHOW, seg SHALL be the hex pattern of shadow nibble idx:
  - 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
  - Full 0-F table per the standard hex font.
REQ-019 seg and anode SHALL be registered and change on the same clk edge, with no glitch between them.
REQ-020 A load pulse SHALL capture digits and digit_en into a pending register and set pend_valid.
REQ-021 At a frame wrap with pend_valid=1, pending SHALL be copied to shadow and pend_valid cleared; the display never changes mid-frame.
REQ-022 If load coincides with a wrap cycle, that cycle's inputs SHALL go directly to shadow, and pend_valid SHALL be cleared.
REQ-023 Multiple loads within one frame SHALL result in the last one winning.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter (minimum 1 bit), with no overflow at the maximum legal value.

Reset
REQ-025 Asserting reset SHALL asynchronously force:
  - state BLANK (SHOW if BLANK_CYCLES=0), idx=0, counters=0;
  - seg=7'h7F, anode all ones, frame_done=0;
  - shadow digits=0, shadow_en all zeros, pend_valid=0.
REQ-026 Reset asserted mid-slot SHALL blank the outputs immediately, with no partial-slot completion.
REQ-027 After reset deasserts, the first SHOW of digit 0 SHALL begin after BLANK_CYCLES cycles.

Structure
REQ-028 Package seg_pkg SHALL hold:
  - the state enum (BLANK, SHOW);
  - the SEG_OFF constant 7'h7F;
  - the hex-to-segment constant table.
REQ-029 The hex decode SHALL be the single sub-module seg_hex_decode (4-bit in, 7-bit active-low out, combinational).
REQ-030 All other logic SHALL reside in seg_mux_n.

Verification (NUM_DIGITS=2, REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-031 Reset, then load digits=8'h81, digit_en=2'b11 -> after the first wrap, the sequence repeats:
  - 2 cycles blank;
  - 4 cycles anode=2'b10, seg=7'b1111001;
  - 2 cycles blank;
  - 4 cycles anode=2'b01, seg=7'b0000000.
REQ-032 Free-run for 3 frames -> frame_done pulses exactly every 12 cycles; the anode never has two bits low at once.
REQ-033 digit_en=2'b10 -> digit 0 slot has anode=2'b11 for 4 cycles; the period stays 12 cycles.
REQ-034 Load 8'h0F mid-frame, then 8'hF0 two cycles later -> the current frame is unchanged; the next frame shows F on digit 1 and 0 on digit 0.
REQ-035 Load coincident with a wrap cycle -> the new value is shown starting in the immediately following frame.
REQ-036 Reset asserted during SHOW of digit 1 -> in the same cycle: seg=7'h7F, anode=2'b11, frame_done=0; restart timing matches REQ-027.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
//   state_t    : slot FSM states (BLANK dead time, SHOW digit lit)
//   SEG_OFF    : active-low segment value with every segment dark
//   HEX_FONT   : active-low hex font, index = nibble, bit0=a ... bit6=g
//   cnt_width  : counter width for a count of n (never less than 1 bit)
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  // Width needed to hold 0..n-1; a 1-bit floor keeps degenerate counts legal.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low segments, bit0=a ... bit6=g
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg_mux_n.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each digit gets a slot of BLANK_CYCLES dead time followed by REFRESH_DIV
// cycles lit. New content is staged in a pending register and only moves to
// the displayed (shadow) copy at a frame wrap, so a frame is never torn.
//
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   digits     : hex nibbles, nibble i drives digit i
//   digit_en   : per-digit enable, 0 keeps that digit dark for its slot
//   load       : single-cycle strobe; the cycle it is high, digits/digit_en
//                are sampled. There is no back-pressure: every strobe is
//                accepted and a later strobe overwrites an earlier pending one.
//   seg        : registered active-low segments
//   anode      : registered active-low digit selects, at most one low
//   frame_done : registered, high during the cycle in which idx wraps to 0
module seg_mux_n
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 2400,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  // One counter serves both phases, so it is sized for the longer one.
  localparam int CW = cnt_width((REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES);
  localparam int IW = cnt_width(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  // With no dead time the FSM lives permanently in SHOW.
  localparam state_t        RESET_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] shadow_dig, shadow_dig_n;
  logic [NUM_DIGITS-1:0]   shadow_en, shadow_en_n;
  logic [4*NUM_DIGITS-1:0] pend_dig, pend_dig_n;
  logic [NUM_DIGITS-1:0]   pend_en, pend_en_n;
  logic                    pend_valid, pend_valid_n;

  logic [3:0]              nibble_n;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic                    frame_done_n;

  // Slot sequencing.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    wrap    = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_n   = '0;
          state_n = (BLANK_CYCLES == 0) ? SHOW : BLANK;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            wrap  = 1'b1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
    endcase
  end

  // Content staging. A strobe landing on the wrap cycle bypasses the pending
  // register so it appears in the very next frame.
  always_comb begin
    shadow_dig_n = shadow_dig;
    shadow_en_n  = shadow_en;
    pend_dig_n   = pend_dig;
    pend_en_n    = pend_en;
    pend_valid_n = pend_valid;
    if (wrap) begin
      if (load) begin
        shadow_dig_n = digits;
        shadow_en_n  = digit_en;
      end else if (pend_valid) begin
        shadow_dig_n = pend_dig;
        shadow_en_n  = pend_en;
      end
      pend_valid_n = 1'b0;
    end else if (load) begin
      pend_dig_n   = digits;
      pend_en_n    = digit_en;
      pend_valid_n = 1'b1;
    end
  end

  // Outputs are computed from next-state values and registered, so seg and
  // anode line up with the FSM state and switch on the same edge.
  assign nibble_n = shadow_dig_n[4*idx_n +: 4];

  seg_hex_decode u_dec (
    .nibble (nibble_n),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_n   = SEG_OFF;
    anode_n = '1;
    if (state_n == SHOW && shadow_en_n[idx_n]) begin
      seg_n   = dec_seg;
      anode_n = ~(NUM_DIGITS'(1) << idx_n);
    end
    frame_done_n = (state_n == SHOW) && (cnt_n == SHOW_LAST) && (idx_n == IDX_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      idx        <= '0;
      shadow_dig <= '0;
      shadow_en  <= '0;
      pend_dig   <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
      seg        <= SEG_OFF;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shadow_dig <= shadow_dig_n;
      shadow_en  <= shadow_en_n;
      pend_dig   <= pend_dig_n;
      pend_en    <= pend_en_n;
      pend_valid <= pend_valid_n;
      seg        <= seg_n;
      anode      <= anode_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
